// File: rtl/vdma_reg_pkg.sv
// Register map, response codes, field widths and FSM state types for the VDMA AXI-Lite slave.
// Optional STRIDE register is present only when VDMA_STRIDE_REG_EN is defined.
package vdma_reg_pkg;

  localparam logic [7:0] ADDR_VDMACR = 8'h30;
  localparam logic [7:0] ADDR_VDMASR = 8'h34;
  localparam logic [7:0] ADDR_VSIZE  = 8'hA0;
  localparam logic [7:0] ADDR_HSIZE  = 8'hA4;
  localparam logic [7:0] ADDR_STRIDE = 8'hA8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int VSIZE_W  = 13;
  localparam int HSIZE_W  = 16;
  localparam int STRIDE_W = 16;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic addr_mapped(input logic [7:0] a);
    case (a)
      ADDR_VDMACR, ADDR_VDMASR, ADDR_VSIZE, ADDR_HSIZE: return 1'b1;
`ifdef VDMA_STRIDE_REG_EN
      ADDR_STRIDE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axil_vdma_reg_slave.sv
// AXI4-Lite register slave for the VDMA MM2S configuration registers.
// Define VDMA_STRIDE_REG_EN to add the STRIDE register at 0xA8.
module axil_vdma_reg_slave
  import vdma_reg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic                        cfg_run,
  output logic                        cfg_circular,
  output logic [HSIZE_W-1:0]          cfg_hsize,
  output logic [VSIZE_W-1:0]          cfg_vsize,
  output logic [STRIDE_W-1:0]         cfg_stride,
  output logic                        cfg_start
);

  w_state_t              w_state_reg;
  r_state_t              r_state_reg;
  logic [7:0]            aw_addr_reg;
  logic [31:0]           w_data_reg;
  logic [3:0]            w_strb_reg;
  logic [1:0]            bresp_reg;
  logic [31:0]           rdata_reg;
  logic [1:0]            rresp_reg;
  logic                  run_reg;
  logic                  circ_reg;
  logic [VSIZE_W-1:0]    vsize_reg;
  logic [HSIZE_W-1:0]    hsize_reg;
  logic                  start_reg;

  logic                  wr_commit;
  logic [7:0]            wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [31:0]           wr_cur;
  logic [31:0]           wr_merged;
  logic [31:0]           rd_word;

  // Commit uses whichever half arrives live this cycle, the other half from the latches.
  always_comb begin
    wr_commit = 1'b0;
    wr_addr   = S_AXI_AWADDR[7:0];
    wr_data   = S_AXI_WDATA;
    wr_strb   = S_AXI_WSTRB;
    case (w_state_reg)
      W_IDLE:      wr_commit = S_AXI_AWVALID & S_AXI_WVALID;
      W_WAIT_DATA: begin wr_commit = S_AXI_WVALID;  wr_addr = aw_addr_reg; end
      W_WAIT_ADDR: begin wr_commit = S_AXI_AWVALID; wr_data = w_data_reg; wr_strb = w_strb_reg; end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_reg <= W_IDLE;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (wr_commit) bresp_reg <= addr_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      case (w_state_reg)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            w_state_reg <= W_RESP;
          end else if (S_AXI_AWVALID) begin
            aw_addr_reg <= S_AXI_AWADDR[7:0];
            w_state_reg <= W_WAIT_DATA;
          end else if (S_AXI_WVALID) begin
            w_data_reg  <= S_AXI_WDATA;
            w_strb_reg  <= S_AXI_WSTRB;
            w_state_reg <= W_WAIT_ADDR;
          end
        end
        W_WAIT_DATA: if (S_AXI_WVALID)  w_state_reg <= W_RESP;
        W_WAIT_ADDR: if (S_AXI_AWVALID) w_state_reg <= W_RESP;
        W_RESP:      if (S_AXI_BREADY)  w_state_reg <= W_IDLE;
        default:     w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_cur = '0;
    case (wr_addr)
      ADDR_VDMACR: wr_cur = {30'd0, circ_reg, run_reg};
      ADDR_VSIZE:  wr_cur = {{(32-VSIZE_W){1'b0}}, vsize_reg};
      ADDR_HSIZE:  wr_cur = {{(32-HSIZE_W){1'b0}}, hsize_reg};
`ifdef VDMA_STRIDE_REG_EN
      ADDR_STRIDE: wr_cur = {{(32-STRIDE_W){1'b0}}, cfg_stride};
`endif
      default: ;
    endcase
    wr_merged = apply_strb(wr_cur, wr_data, wr_strb);
  end

`ifdef VDMA_STRIDE_REG_EN
  logic [STRIDE_W-1:0] stride_reg;
  assign cfg_stride = stride_reg;
`else
  assign cfg_stride = hsize_reg;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run_reg    <= 1'b0;
      circ_reg   <= 1'b0;
      vsize_reg  <= '0;
      hsize_reg  <= '0;
      start_reg  <= 1'b0;
`ifdef VDMA_STRIDE_REG_EN
      stride_reg <= '0;
`endif
    end else begin
      start_reg <= 1'b0;
      if (wr_commit) begin
        case (wr_addr)
          ADDR_VDMACR: begin
            // Soft reset wins over the RS/Circular bits written alongside it.
            if (wr_merged[2]) begin
              run_reg    <= 1'b0;
              circ_reg   <= 1'b0;
              vsize_reg  <= '0;
              hsize_reg  <= '0;
`ifdef VDMA_STRIDE_REG_EN
              stride_reg <= '0;
`endif
            end else begin
              run_reg  <= wr_merged[0];
              circ_reg <= wr_merged[1];
            end
          end
          ADDR_VSIZE: begin
            vsize_reg <= wr_merged[VSIZE_W-1:0];
            start_reg <= run_reg && (wr_merged[VSIZE_W-1:0] != '0);
          end
          ADDR_HSIZE:  hsize_reg  <= wr_merged[HSIZE_W-1:0];
`ifdef VDMA_STRIDE_REG_EN
          ADDR_STRIDE: stride_reg <= wr_merged[STRIDE_W-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[7:0])
      ADDR_VDMACR: rd_word = {30'd0, circ_reg, run_reg};
      ADDR_VDMASR: rd_word = {31'd0, ~run_reg};
      ADDR_VSIZE:  rd_word = {{(32-VSIZE_W){1'b0}}, vsize_reg};
      ADDR_HSIZE:  rd_word = {{(32-HSIZE_W){1'b0}}, hsize_reg};
`ifdef VDMA_STRIDE_REG_EN
      ADDR_STRIDE: rd_word = {{(32-STRIDE_W){1'b0}}, cfg_stride};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_reg <= R_IDLE;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: if (S_AXI_ARVALID) begin
          rdata_reg   <= rd_word;
          rresp_reg   <= addr_mapped(S_AXI_ARADDR[7:0]) ? RESP_OKAY : RESP_SLVERR;
          r_state_reg <= R_DATA;
        end
        R_DATA:  if (S_AXI_RREADY) r_state_reg <= R_IDLE;
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = (w_state_reg == W_IDLE) || (w_state_reg == W_WAIT_ADDR);
  assign S_AXI_WREADY  = (w_state_reg == W_IDLE) || (w_state_reg == W_WAIT_DATA);
  assign S_AXI_BVALID  = (w_state_reg == W_RESP);
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = (r_state_reg == R_IDLE);
  assign S_AXI_RVALID  = (r_state_reg == R_DATA);
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;

  assign cfg_run      = run_reg;
  assign cfg_circular = circ_reg;
  assign cfg_hsize    = hsize_reg;
  assign cfg_vsize    = vsize_reg;
  assign cfg_start    = start_reg;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[AXI_ADDR_WIDTH-1:8],
                       S_AXI_ARADDR[AXI_ADDR_WIDTH-1:8], wr_merged[31:16]};

endmodule

// File: tb/tb_axil_vdma_reg_slave.sv
// Directed bench for axil_vdma_reg_slave; expectations adapt to VDMA_STRIDE_REG_EN.
module tb_axil_vdma_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        cfg_run, cfg_circular, cfg_start;
  logic [15:0] cfg_hsize, cfg_stride;
  logic [12:0] cfg_vsize;

  int total = 0;
  int bad = 0;
  int starts = 0;

  always #5 clk = ~clk;

  axil_vdma_reg_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_run(cfg_run), .cfg_circular(cfg_circular), .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize),
    .cfg_stride(cfg_stride), .cfg_start(cfg_start)
  );

  always @(negedge clk) if (cfg_start === 1'b1) starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0; w_done = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    resp = 2'b11;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
    $display("write addr=0x%03h data=0x%08h strb=%b resp=%0d", a, d, s, resp);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                    output logic lat_ok);
    logic hs, pre;
    hs = 1'b0; pre = 1'b1; lat_ok = 1'b0;
    data = 'x; resp = 2'b11;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk);
      hs  = arready;
      pre = rvalid;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (hs) begin
      @(negedge clk);
      lat_ok = !pre && rvalid;
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
    $display("read  addr=0x%03h data=0x%08h resp=%0d lat_ok=%0d", a, data, resp, lat_ok);
  endtask

  logic [1:0]  resp;
  logic [31:0] data;
  logic        lat;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready",  {31'd0, wready},  32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk("rst_cfg", {cfg_run, cfg_circular, cfg_start, cfg_hsize, cfg_vsize}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic setup writes
    wr(32'h30, 32'h3, 4'hF, resp);   chk("wr_cr_resp", {30'd0, resp}, 32'd0);
    wr(32'hA4, 32'd640, 4'hF, resp); chk("wr_hs_resp", {30'd0, resp}, 32'd0);
    wr(32'hA0, 32'd480, 4'hF, resp); chk("wr_vs_resp", {30'd0, resp}, 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("cfg_run",   {31'd0, cfg_run}, 32'd1);
    chk("cfg_circ",  {31'd0, cfg_circular}, 32'd1);
    chk("cfg_hsize", {16'd0, cfg_hsize}, 32'd640);
    chk("cfg_vsize", {19'd0, cfg_vsize}, 32'd480);
    chk("start_cnt1", starts, 32'd1);
`ifdef VDMA_STRIDE_REG_EN
    chk("cfg_stride0", {16'd0, cfg_stride}, 32'd0);
`else
    chk("cfg_stride_tie", {16'd0, cfg_stride}, 32'd640);
`endif

    // Readback
    rd(32'h30, data, resp, lat); chk("rd_cr", data, 32'h3); chk("rd_cr_lat", {31'd0, lat}, 32'd1);
    chk("rd_cr_resp", {30'd0, resp}, 32'd0);
    rd(32'hA4, data, resp, lat); chk("rd_hs", data, 32'd640); chk("rd_hs_lat", {31'd0, lat}, 32'd1);
    rd(32'hA0, data, resp, lat); chk("rd_vs", data, 32'd480); chk("rd_vs_resp", {30'd0, resp}, 32'd0);
    rd(32'h34, data, resp, lat); chk("rd_sr", data, 32'h0); chk("rd_sr_resp", {30'd0, resp}, 32'd0);

    // W three cycles ahead of AW, with BREADY held low for four cycles
    wdata = 32'd800; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1; wvalid = 1'b0;
    @(negedge clk); chk("wfirst_awready", {31'd0, awready}, 32'd1);
    chk("wfirst_wready", {31'd0, wready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 32'hA4; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    chk("wfirst_resp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    chk("wfirst_bvalid_clr", {31'd0, bvalid}, 32'd0);
    chk("wfirst_hsize", {16'd0, cfg_hsize}, 32'd800);

    // AW three cycles ahead of W
    awaddr = 32'h30; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    @(negedge clk); chk("awfirst_awready", {31'd0, awready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    @(negedge clk); chk("awfirst_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1; bready = 1'b0;
    chk("awfirst_run", {31'd0, cfg_run}, 32'd1);
    chk("awfirst_circ", {31'd0, cfg_circular}, 32'd0);

    // Unmapped address
    wr(32'h200, 32'hFFFF_FFFF, 4'hF, resp); chk("unmap_wr_resp", {30'd0, resp}, 32'd2);
    rd(32'h200, data, resp, lat);
    chk("unmap_rd_data", data, 32'd0); chk("unmap_rd_resp", {30'd0, resp}, 32'd2);
    chk("unmap_hsize", {16'd0, cfg_hsize}, 32'd800);
    chk("unmap_run", {31'd0, cfg_run}, 32'd1);

    // Byte strobes
    wr(32'hA4, 32'h0, 4'hF, resp);
    wr(32'hA4, 32'hFFFF, 4'b0001, resp);
    chk("strb_hsize", {16'd0, cfg_hsize}, 32'h00FF);
    wr(32'hA4, 32'd640, 4'hF, resp);

    // STRIDE register presence
`ifdef VDMA_STRIDE_REG_EN
    wr(32'hA8, 32'h1234, 4'hF, resp); chk("stride_wr_resp", {30'd0, resp}, 32'd0);
    chk("stride_cfg", {16'd0, cfg_stride}, 32'h1234);
    rd(32'hA8, data, resp, lat); chk("stride_rd", data, 32'h1234);
    chk("stride_rd_resp", {30'd0, resp}, 32'd0);
`else
    wr(32'hA8, 32'h1234, 4'hF, resp); chk("stride_wr_resp", {30'd0, resp}, 32'd2);
    chk("stride_cfg", {16'd0, cfg_stride}, 32'd640);
    rd(32'hA8, data, resp, lat); chk("stride_rd", data, 32'h0);
    chk("stride_rd_resp", {30'd0, resp}, 32'd2);
`endif

    // Frame-start: nonzero VSIZE with RS=1 pulses, zero VSIZE does not
    wr(32'hA0, 32'h10, 4'hF, resp);
    wr(32'hA0, 32'h0, 4'hF, resp);
    repeat (2) @(posedge clk); #1;
    chk("start_cnt2", starts, 32'd2);

    // Soft reset
    wr(32'hA0, 32'd480, 4'hF, resp);
    wr(32'h30, 32'h4, 4'hF, resp); chk("srst_resp", {30'd0, resp}, 32'd0);
    chk("srst_cfg", {cfg_run, cfg_circular, cfg_start, cfg_hsize, cfg_vsize}, 32'd0);
    chk("srst_stride", {16'd0, cfg_stride}, 32'd0);
    rd(32'h30, data, resp, lat); chk("srst_rd_cr", data, 32'd0);
    rd(32'h34, data, resp, lat); chk("srst_rd_sr", data, 32'd1);
    chk("start_cnt3", starts, 32'd3);

    // Field truncation with RS=0: no start pulse
    wr(32'hA0, 32'hFFFF_FFFF, 4'hF, resp);
    rd(32'hA0, data, resp, lat); chk("vsize_trunc", data, 32'h1FFF);

    // Reset while BVALID is high
    awaddr = 32'h30; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pre_rst_run", {31'd0, cfg_run}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_bvalid", {31'd0, bvalid}, 32'd0);
    chk("async_run", {31'd0, cfg_run}, 32'd0);
    chk("async_awready", {31'd0, awready}, 32'd1);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr(32'hA4, 32'd5, 4'hF, resp); chk("post_rst_resp", {30'd0, resp}, 32'd0);
    chk("post_rst_hsize", {16'd0, cfg_hsize}, 32'd5);

    // Same-edge read and write of HSIZE: read sees the old value
    awaddr = 32'hA4; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'hA4; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("same_rvalid", {31'd0, rvalid}, 32'd1);
    chk("same_rdata", rdata, 32'd5);
    chk("same_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1; bready = 1'b0; rready = 1'b0;
    chk("same_hsize", {16'd0, cfg_hsize}, 32'd7);
    $display("same-edge rd/wr hsize old=5 new=%0d", cfg_hsize);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
